// File: rtl/avg_pool2x2_stream_if.sv
// Pixel-in / pooled-value-out stream bundle for avg_pool2x2_stream.
// master = upstream/consumer side (testbench or neighbouring stages), slave = pooling unit.
interface avg_pool2x2_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  mode;
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  frame_done;
  logic                  busy;

  modport master (
    output mode, in_valid, in_sof, in_data,
    input  out_valid, out_data, frame_done, busy
  );

  modport slave (
    input  mode, in_valid, in_sof, in_data,
    output out_valid, out_data, frame_done, busy
  );
endinterface

// File: rtl/avg_pool2x2_stream.sv
// 2x2 stride-2 average/max pooling over a raster pixel stream; result registered one cycle after a window's 4th pixel.
// No backpressure: every pixel is accepted and every out_valid pulse must be taken downstream.
module avg_pool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int ROUND_EN   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  avg_pool2x2_stream_if.slave s_if
);
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LD = IMG_W / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic signed [DATA_WIDTH+1:0] RND = (ROUND_EN != 0) ? (DATA_WIDTH+2)'(2) : '0;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic                          r_mode_q;
  logic signed [DATA_WIDTH-1:0]  r_hold;
  logic signed [DATA_WIDTH:0]    r_line [LD];
  logic                          r_out_valid;
  logic [DATA_WIDTH-1:0]         r_out_data;
  logic                          r_frame_done;

  logic [CW-1:0]                 w_col;
  logic [CW-1:0]                 w_col_nxt;
  logic [RW-1:0]                 w_row;
  logic [RW-1:0]                 w_row_nxt;
  logic                          w_col_last;
  logic                          w_row_last;
  logic                          w_origin;
  logic                          w_win_done;
  logic                          w_frame_end;
  logic [LW-1:0]                 w_idx;
  logic signed [DATA_WIDTH-1:0]  w_pix;
  logic signed [DATA_WIDTH:0]    w_pair_sum;
  logic signed [DATA_WIDTH:0]    w_pair_max;
  logic signed [DATA_WIDTH:0]    w_pair;
  logic signed [DATA_WIDTH:0]    w_lb;
  logic signed [DATA_WIDTH+1:0]  w_quad_sum;
  logic signed [DATA_WIDTH:0]    w_quad_max;
  logic signed [DATA_WIDTH-1:0]  w_result;

  // A start-of-frame pixel is treated as (0,0) whatever the counters say.
  assign w_col       = s_if.in_sof ? '0 : r_col;
  assign w_row       = s_if.in_sof ? '0 : r_row;
  assign w_col_last  = (w_col == COL_MAX);
  assign w_row_last  = (w_row == ROW_MAX);
  assign w_col_nxt   = w_col_last ? '0 : w_col + 1'b1;
  assign w_row_nxt   = w_col_last ? (w_row_last ? '0 : w_row + 1'b1) : w_row;
  assign w_origin    = (w_col == '0) && (w_row == '0);
  assign w_win_done  = s_if.in_valid && w_col[0] && w_row[0];
  assign w_frame_end = w_win_done && w_col_last && w_row_last;
  assign w_idx       = LW'(w_col >> 1);
  assign w_pix       = s_if.in_data;
  assign w_lb        = r_line[w_idx];

  always_comb begin
    w_pair_sum = {r_hold[DATA_WIDTH-1], r_hold} + {w_pix[DATA_WIDTH-1], w_pix};
    w_pair_max = (w_pix > r_hold) ? {w_pix[DATA_WIDTH-1], w_pix}
                                  : {r_hold[DATA_WIDTH-1], r_hold};
    w_pair     = r_mode_q ? w_pair_max : w_pair_sum;
    // Sums carry two guard bits so the 4-pixel total never wraps.
    w_quad_sum = {w_lb[DATA_WIDTH], w_lb} + {w_pair[DATA_WIDTH], w_pair} + RND;
    w_quad_max = (w_pair > w_lb) ? w_pair : w_lb;
    w_result   = r_mode_q ? DATA_WIDTH'(w_quad_max) : DATA_WIDTH'(w_quad_sum >>> 2);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (s_if.in_valid) begin
      w_state_nxt = (w_col_last && w_row_last) ? S_IDLE : S_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_mode_q     <= 1'b0;
      r_hold       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (s_if.in_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        if (w_origin) begin
          r_mode_q <= s_if.mode;
        end
        if (!w_col[0]) begin
          r_hold <= w_pix;
        end
        if (w_win_done) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= w_result;
          r_frame_done <= w_frame_end;
        end
      end
    end
  end

  // Entries are always written on an even row before the odd row reads them.
  always_ff @(posedge i_clk) begin
    if (s_if.in_valid && w_col[0] && !w_row[0]) begin
      r_line[w_idx] <= w_pair;
    end
  end

  assign s_if.out_valid  = r_out_valid;
  assign s_if.out_data   = r_out_data;
  assign s_if.frame_done = r_frame_done;
  assign s_if.busy       = (r_state == S_RUN);
endmodule

// File: tb/tb_avg_pool2x2_stream.sv
// Directed bench: 4x2 frames on floor and round instances, plus a 28x28 frame with and without bubbles.
module tb_avg_pool2x2_stream;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avg_pool2x2_stream_if #(.DATA_WIDTH(DW)) if_f ();
  avg_pool2x2_stream_if #(.DATA_WIDTH(DW)) if_r ();
  avg_pool2x2_stream_if #(.DATA_WIDTH(DW)) if_b ();

  assign if_r.mode     = if_f.mode;
  assign if_r.in_valid = if_f.in_valid;
  assign if_r.in_sof   = if_f.in_sof;
  assign if_r.in_data  = if_f.in_data;

  avg_pool2x2_stream #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(2), .ROUND_EN(0)) u_f (
    .i_clk(clk), .i_rst_n(rst_n), .s_if(if_f));
  avg_pool2x2_stream #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(2), .ROUND_EN(1)) u_r (
    .i_clk(clk), .i_rst_n(rst_n), .s_if(if_r));
  avg_pool2x2_stream #(.DATA_WIDTH(DW), .IMG_W(28), .IMG_H(28), .ROUND_EN(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .s_if(if_b));

  typedef struct {
    logic signed [DW-1:0] px [8];
    logic                 md;
    int                   ef [2];
    int                   er [2];
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic px_f(input int d, input logic sof, input logic md);
    @(negedge clk);
    if_f.in_valid = 1'b1;
    if_f.in_sof   = sof;
    if_f.in_data  = DW'(d);
    if_f.mode     = md;
    @(posedge clk);
    #1;
    if_f.in_valid = 1'b0;
    if_f.in_sof   = 1'b0;
  endtask

  task automatic px_b(input int d, input logic sof);
    @(negedge clk);
    if_b.in_valid = 1'b1;
    if_b.in_sof   = sof;
    if_b.in_data  = DW'(d);
    @(posedge clk);
    #1;
    if_b.in_valid = 1'b0;
    if_b.in_sof   = 1'b0;
  endtask

  // Window 0 completes on pixel 5, window 1 (last of frame) on pixel 7.
  task automatic run_frame(input vec_t v, input bit sof0, input bit first_sent, input string tag);
    for (int p = (first_sent ? 1 : 0); p < 8; p++) begin
      bit exp_v;
      px_f(v.px[p], (p == 0) && sof0, (p == 0) ? v.md : ~v.md);
      exp_v = (p == 5) || (p == 7);
      chk({tag, " out_valid"}, int'(if_f.out_valid), int'(exp_v));
      chk({tag, " frame_done"}, int'(if_f.frame_done), int'(p == 7));
      chk({tag, " busy"}, int'(if_f.busy), int'(p != 7));
      if (exp_v) begin
        chk({tag, " floor data"}, $signed(if_f.out_data), v.ef[(p == 7) ? 1 : 0]);
        chk({tag, " round data"}, $signed(if_r.out_data), v.er[(p == 7) ? 1 : 0]);
      end
    end
  endtask

  logic signed [DW-1:0] img [28][28];
  int exp_q[$];
  int got_q[$];
  int fd_cnt = 0;

  always @(negedge clk) begin
    if (if_b.out_valid === 1'b1) begin
      got_q.push_back($signed(if_b.out_data));
      if (if_b.frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic run_big(input bit gaps, input string tag);
    got_q.delete();
    fd_cnt = 0;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
        px_b(img[r][c], (r == 0) && (c == 0));
      end
    end
    repeat (3) @(posedge clk);
    chk({tag, " pulses"}, got_q.size(), 196);
    chk({tag, " frame_done count"}, fd_cnt, 1);
    for (int k = 0; k < 196; k++) begin
      chk({tag, " window"}, (k < got_q.size()) ? got_q[k] : -999999, exp_q[k]);
    end
  endtask

  vec_t vt [6];

  initial begin
    vt[0].px = '{1, 2, 3, 4, 5, 6, 7, 8};
    vt[0].md = 1'b0; vt[0].ef = '{3, 5}; vt[0].er = '{4, 6};
    vt[1].px = '{-1, -2, -1, -1, -2, -2, -1, -2};
    vt[1].md = 1'b0; vt[1].ef = '{-2, -2}; vt[1].er = '{-2, -1};
    vt[2].px = '{32767, 32767, -32768, -32768, 32767, 32767, -32768, -32768};
    vt[2].md = 1'b0; vt[2].ef = '{32767, -32768}; vt[2].er = '{32767, -32768};
    vt[3].px = '{-5, -9, 10, -20, -3, -7, 0, 7};
    vt[3].md = 1'b1; vt[3].ef = '{-3, 10}; vt[3].er = '{-3, 10};
    vt[4].px = '{32767, -32768, -32768, -32768, 0, 1, -32768, -32768};
    vt[4].md = 1'b1; vt[4].ef = '{32767, -32768}; vt[4].er = '{32767, -32768};
    vt[5].px = '{100, -50, 3, 3, 25, -75, 3, 2};
    vt[5].md = 1'b0; vt[5].ef = '{0, 2}; vt[5].er = '{0, 3};

    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        img[r][c] = DW'($urandom);
    for (int wr = 0; wr < 14; wr++)
      for (int wc = 0; wc < 14; wc++)
        exp_q.push_back((int'(img[2*wr][2*wc]) + int'(img[2*wr][2*wc+1]) +
                         int'(img[2*wr+1][2*wc]) + int'(img[2*wr+1][2*wc+1])) >>> 2);

    rst_n = 1'b0;
    if_f.in_valid = 1'b0; if_f.in_sof = 1'b0; if_f.in_data = '0; if_f.mode = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_sof = 1'b0; if_b.in_data = '0; if_b.mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(if_f.out_valid), 0);
    chk("reset out_data", int'(if_f.out_data), 0);
    chk("reset frame_done", int'(if_f.frame_done), 0);
    chk("reset busy", int'(if_f.busy), 0);
    chk("reset big busy", int'(if_b.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back frames; odd entries start by natural wrap, mode toggles mid-frame.
    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i], (i % 2) == 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Resync: sof lands where pixel (row1,col3) would be.
    px_f(10, 1'b1, 1'b0); px_f(20, 1'b0, 1'b0); px_f(30, 1'b0, 1'b0); px_f(40, 1'b0, 1'b0);
    px_f(50, 1'b0, 1'b0); px_f(60, 1'b0, 1'b0);
    chk("resync pre window", $signed(if_f.out_data), 35);
    px_f(70, 1'b0, 1'b0);
    px_f(vt[0].px[0], 1'b1, vt[0].md);
    chk("resync sof out_valid", int'(if_f.out_valid), 0);
    chk("resync sof frame_done", int'(if_f.frame_done), 0);
    chk("resync sof busy", int'(if_f.busy), 1);
    run_frame(vt[0], 1'b1, 1'b1, "resync");

    // Reset mid-row1, then a frame entered by natural (0,0).
    px_f(9, 1'b1, 1'b0); px_f(9, 1'b0, 1'b0); px_f(9, 1'b0, 1'b0); px_f(9, 1'b0, 1'b0);
    px_f(9, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset out_valid", int'(if_f.out_valid), 0);
    chk("midreset out_data", int'(if_f.out_data), 0);
    chk("midreset frame_done", int'(if_f.frame_done), 0);
    chk("midreset busy", int'(if_f.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(vt[1], 1'b0, 1'b0, "postreset");

    run_big(1'b0, "big nogap");
    run_big(1'b1, "big bubbles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
